// File: rtl/hamming_decoder_engine.sv
// Hamming(16,11) SECDED receive engine: walks codewords in data memory,
// corrects single errors, flags double errors and writes messages back.
module hamming_decoder_engine #(
    parameter int IN_BASE   = 30,
    parameter int OUT_BASE  = 0,
    parameter int NUM_WORDS = 15,
    parameter int AW        = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rd_data,
    output logic          mem_wr_en,
    output logic [7:0]    mem_wr_data
);

    localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        DECODE,
        WR_LO,
        WR_HI,
        DONE
    } state_t;

    state_t        state;
    state_t        nxt;
    logic [IW-1:0] idx;
    logic [7:0]    c_lo;
    logic [7:0]    c_hi;
    logic [10:0]   dat;
    logic [1:0]    flg;

    logic          last;
    logic [AW-1:0] off;
    logic [AW-1:0] in_lo;
    logic [AW-1:0] out_lo;

    assign last   = (idx == IW'(NUM_WORDS - 1));
    assign off    = AW'({idx, 1'b0});
    assign in_lo  = AW'(IN_BASE) + off;
    assign out_lo = AW'(OUT_BASE) + off;

    logic [15:0] cw;
    logic [15:0] cc;
    logic [3:0]  syn;
    logic        par;
    logic [10:0] dec_data;
    logic [1:0]  dec_flg;

    always_comb begin
        cw  = {c_hi, c_lo};
        syn = 4'd0;
        for (int k = 1; k < 16; k++) begin
            if (cw[k]) syn = syn ^ 4'(k);
        end
        par = ^cw;
        cc  = cw;
        // syndrome 0 with odd parity means only p0 flipped
        if (par && (syn != 4'd0)) cc[syn] = ~cc[syn];
        dec_data = {cc[15:9], cc[7:5], cc[3]};
        if (par) begin
            dec_flg = 2'b01;
        end else if (syn != 4'd0) begin
            dec_flg = 2'b10;
        end else begin
            dec_flg = 2'b00;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (req) nxt = RD_LO;
            RD_LO:   nxt = RD_HI;
            RD_HI:   nxt = DECODE;
            DECODE:  nxt = WR_LO;
            WR_LO:   nxt = WR_HI;
            WR_HI:   nxt = last ? DONE : RD_LO;
            DONE:    if (req) nxt = RD_LO;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_addr    = '0;
        mem_wr_en   = 1'b0;
        mem_wr_data = 8'd0;
        done        = 1'b0;
        case (state)
            RD_LO: mem_addr = in_lo;
            RD_HI: mem_addr = in_lo + AW'(1);
            WR_LO: begin
                mem_addr    = out_lo;
                mem_wr_en   = 1'b1;
                mem_wr_data = dat[7:0];
            end
            WR_HI: begin
                mem_addr    = out_lo + AW'(1);
                mem_wr_en   = 1'b1;
                mem_wr_data = {flg, 3'b000, dat[10:8]};
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            c_lo  <= 8'd0;
            c_hi  <= 8'd0;
            dat   <= 11'd0;
            flg   <= 2'b00;
        end else begin
            state <= nxt;
            case (state)
                RD_LO: c_lo <= mem_rd_data;
                RD_HI: c_hi <= mem_rd_data;
                DECODE: begin
                    dat <= dec_data;
                    flg <= dec_flg;
                end
                WR_HI: if (!last) idx <= idx + IW'(1);
                DONE:  if (req) idx <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_decoder_engine.sv
// Directed bench for hamming_decoder_engine with a byte-wide memory model.
module tb_hamming_decoder_engine;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req = 1'b0;
    logic       done;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;

    hamming_decoder_engine dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .done        (done),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data)
    );

    always #5 clk = ~clk;

    logic [7:0] mem   [256];
    logic [7:0] image [256];
    logic       load = 1'b0;
    int         wr_cnt = 0;
    int         bad_cnt = 0;

    assign mem_rd_data = mem[mem_addr];

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 256; i++) mem[i] <= image[i];
        end else if (mem_wr_en) begin
            mem[mem_addr] <= mem_wr_data;
            wr_cnt <= wr_cnt + 1;
            if (mem_addr >= 8'd30) bad_cnt <= bad_cnt + 1;
        end
    end

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    logic [15:0] cw [15];
    logic [15:0] ex [15];

    task automatic load_image(input logic [7:0] fill);
        for (int i = 0; i < 256; i++) image[i] = 8'h5A;
        for (int i = 0; i < 30; i++) image[i] = fill;
        for (int i = 0; i < 15; i++) begin
            image[30 + 2*i] = cw[i][7:0];
            image[31 + 2*i] = cw[i][15:8];
        end
        @(negedge clk) load = 1'b1;
        @(negedge clk) load = 1'b0;
    endtask

    task automatic check_words(input string tag);
        for (int i = 0; i < 15; i++)
            check($sformatf("%s_w%0d", tag, i),
                  {16'h0, mem[2*i+1], mem[2*i]}, {16'h0, ex[i]});
    endtask

    task automatic run_pass(input string tag, input bit hold);
        int n;
        int b0;
        b0 = bad_cnt;
        @(negedge clk) req = 1'b1;
        @(posedge clk);
        #1 check({tag, "_done_low"}, done, 0);
        if (!hold) req = 1'b0;
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            n++;
            #1;
            if (done) break;
        end
        req = 1'b0;
        check({tag, "_latency"}, n, 75);
        repeat (3) @(posedge clk);
        #1 check({tag, "_done_hold"}, done, 1);
        check({tag, "_stray_wr"}, bad_cnt - b0, 0);
    endtask

    initial begin
        int w0;
        int bad;
        for (int i = 0; i < 15; i++) begin
            cw[i] = 16'h0000;
            ex[i] = 16'h0000;
        end

        repeat (2) @(posedge clk);
        #1;
        check("rst_done", done, 0);
        check("rst_wr_en", mem_wr_en, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wr_data", mem_wr_data, 0);
        @(negedge clk) rst_n = 1'b1;

        // all-zero codewords
        load_image(8'hAA);
        run_pass("zero", 1'b0);
        check_words("zero");

        // clean, single, p0-only and double errors
        cw[0] = 16'h000F; ex[0] = 16'h0001;
        cw[1] = 16'hFFFF; ex[1] = 16'h07FF;
        cw[2] = 16'h004F; ex[2] = 16'h4001;
        cw[3] = 16'h000E; ex[3] = 16'h4001;
        cw[4] = 16'h024F; ex[4] = 16'h8015;
        cw[5] = 16'h0001; ex[5] = 16'h4000;
        load_image(8'hAA);
        run_pass("mix_hold", 1'b1);
        check_words("mix");

        // restart from DONE with outputs scrubbed
        load_image(8'hCC);
        run_pass("restart", 1'b0);
        check_words("restart");

        // reset mid-run at edge 20
        load_image(8'hEE);
        @(negedge clk) req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_done", done, 0);
        check("midrst_wr_en", mem_wr_en, 0);
        check("midrst_addr", mem_addr, 0);
        w0 = wr_cnt;
        repeat (6) @(posedge clk);
        #1 check("midrst_no_wr", wr_cnt - w0, 0);
        bad = 0;
        for (int i = 8; i < 30; i++) if (mem[i] !== 8'hEE) bad++;
        check("midrst_untouched", bad, 0);
        for (int i = 0; i < 4; i++)
            check($sformatf("midrst_w%0d", i),
                  {mem[2*i+1], mem[2*i]}, ex[i]);
        @(negedge clk) rst_n = 1'b1;
        run_pass("post_rst", 1'b0);
        check_words("post_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hamming_decoder_engine.md
Name: hamming_decoder_engine

Overview:
Memory-walking SECDED decoder, the receive-side counterpart of the program-1 encoder. On `req`, it reads NUM_WORDS 16-bit Hamming(16,11) codewords from data memory starting at IN_BASE. It corrects single errors and flags double errors. It writes the 11-bit messages plus 2 status flags back starting at OUT_BASE, then raises `done`. It sits beside the core in top_level and uses a single data-memory port.

Parameters:
- IN_BASE, 30, byte address of the first codeword (low byte).
- OUT_BASE, 0, byte address of the first decoded word (low byte).
- NUM_WORDS, 15, number of codewords processed per request.
- AW, 8, data-memory address width.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  1  start request; sampled only in IDLE or DONE.
- done  out  1  high while the block is in DONE.
- mem_addr  out  AW  data-memory byte address.
- mem_rd_data  in  8  combinational read data for mem_addr, valid in the same cycle.
- mem_wr_en  out  1  write strobe; memory writes on the rising edge.
- mem_wr_data  out  8  write data.

Behaviour:
Reset:
- Reset is asynchronous and active-low; one clock domain (clk).
- rst_n low forces state IDLE, word index 0, done=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, and clears all datapath registers.
- Reset mid-run aborts immediately. Bytes already written stay written. No further writes occur.

Codeword format (c[15:0]):
- c[7:0] is stored at the even address; c[15:8] at the following odd address.
- c[0] = p0, overall parity.
- c[1], c[2], c[4], c[8] = Hamming parity bits.
- d1..d11 sit at positions 3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15, in that order.

State machine (one cycle per state, word i = 0..NUM_WORDS-1):
- IDLE: if req, go to RD_LO.
- RD_LO: mem_addr = IN_BASE+2i; latch c[7:0].
- RD_HI: mem_addr = IN_BASE+2i+1; latch c[15:8].
- DECODE: register the syndrome, flags and corrected data.
- WR_LO: mem_addr = OUT_BASE+2i; mem_wr_en=1; data = {d8..d1}.
- WR_HI: mem_addr = OUT_BASE+2i+1; mem_wr_en=1; data = {F1, F0, 3'b000, d11, d10, d9}.
  - Then go to RD_LO with i+1, or to DONE if i == NUM_WORDS-1.
- DONE: done=1. If req, clear i and go to RD_LO (done drops the next cycle). Otherwise stay.

Handshake and timing:
- req is ignored in every busy state.
- Outside WR_LO/WR_HI, mem_wr_en=0.
- Latency: done is first high 5*NUM_WORDS clock edges after the req-sampling edge (75 for the defaults).
- The word index wraps only via restart. Addresses are computed modulo 2^AW.

Decode rules:
- s[3:0] = XOR of the indices k in 1..15 where c[k]=1.
- P = XOR of all 16 bits.
- s=0, P=0: no error; F = 00.
- P=1: single error; F = 01.
  - If s≠0, invert c[s] before extracting data.
  - If s=0, the error is in p0 and the data is unchanged.
- s≠0, P=0: double error; F = 10; data is extracted uncorrected.
- F = 11 never occurs.

Test Plan:
1. All 15 codewords 0x0000, pulse req → after 75 edges done=1; mem[0..29] all 0x00; no writes outside 0..29.
2. Codeword 0x000F (d1=1) at word 0 → mem[0]=0x01, mem[1]=0x00. Codeword 0xFFFF at word 1 → mem[2]=0xFF, mem[3]=0x07.
3. Single errors:
   - 0x004F (bit 6 flipped from 0x000F) → mem[0]=0x01, mem[1]=0x40.
   - 0x000E (p0 flipped) → mem[0]=0x01, mem[1]=0x40.
4. Double error 0x024F (bits 6 and 9 flipped from 0x000F) → mem[0]=0x15, mem[1]=0x80.
5. Handshake:
   - Hold req high during the run → no restart; done stays high once reached.
   - Pulse req in DONE → done low next cycle; the full pass repeats with identical results.
6. Drop rst_n at edge 20 of a run → immediately done=0, mem_wr_en=0; no further writes. After release, a req runs a clean full pass.
